// File: rtl/sub_byter_seq.sv
// sub_byter_seq: time-multiplexed AES SubBytes / InvSubBytes stage with valid/ready handshakes.
//
// An accepted 128-bit state is pushed through LANES S-box instances per cycle, so a block takes
// BEATS = 16/LANES cycles. The finished result is held until the downstream side takes it.
//
// Parameters
//   LANES   S-box instances per beat (1, 2, 4, 8 or 16)
//   INV_EN  1: inverse S-boxes built and in_inv honoured; 0: forward only
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   input block offered
//   in_ready   block can be accepted this cycle
//   in_data    input state, byte k = bits [8k:8k+7]
//   in_inv     1 = InvSubBytes, 0 = SubBytes, sampled with the block
//   out_valid  result available
//   out_ready  downstream takes the result
//   out_data   substituted state, same byte layout
//   busy       a block is being processed or is waiting to be taken
module sub_byter_seq #(
    parameter int unsigned LANES  = 4,
    parameter bit          INV_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_data,
    output logic         busy
);

    localparam int unsigned BEATS = 16 / LANES;
    localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] base;
        logic [7:0] e;
        r    = 8'h01;
        base = x;
        e    = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gf_mul(r, base);
            base = gf_mul(base, base);
        end
        return r;
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] v;
        logic [7:0] c;
        logic [7:0] s;
        v = gf_inv(x);
        c = 8'h63;
        for (int i = 0; i < 8; i++) begin
            s[i] = v[i] ^ v[(i + 4) % 8] ^ v[(i + 5) % 8] ^ v[(i + 6) % 8] ^ v[(i + 7) % 8]
                   ^ c[i];
        end
        return s;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] d;
        logic [7:0] u;
        d = 8'h05;
        for (int i = 0; i < 8; i++) begin
            u[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8] ^ d[i];
        end
        return gf_inv(u);
    endfunction

    state_e         state_q, state_d;
    logic [CW-1:0]  beat_q, beat_d;
    logic           mode_q, mode_d;
    logic [0:127]   src_q, src_d;
    logic [0:127]   res_q, res_d;
    logic [7:0]     lane_out [LANES];
    int unsigned    beat_base;
    logic           accept;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            beat_q  <= '0;
            mode_q  <= 1'b0;
            src_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            res_q   <= res_d;
        end
    end

    // Lane datapath: the bytes of the current beat go through the selected S-box.
    always_comb begin
        beat_base = 32'(beat_q) * LANES;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (INV_EN && mode_q) begin
                lane_out[l] = inv_sbox(src_q[8 * (beat_base + l) +: 8]);
            end else begin
                lane_out[l] = fwd_sbox(src_q[8 * (beat_base + l) +: 8]);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        mode_d  = mode_q;
        src_d   = src_q;
        res_d   = res_q;
        accept  = in_valid && in_ready;

        case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    state_d = StRun;
                    beat_d  = '0;
                    mode_d  = INV_EN ? in_inv : 1'b0;
                    src_d   = in_data;
                end else if (state_q == StDone && out_ready) begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    res_d[8 * (beat_base + l) +: 8] = lane_out[l];
                end
                if (beat_q == CW'(BEATS - 1)) begin
                    state_d = StDone;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: all decoded from registers, in_ready additionally from out_ready.
    always_comb begin
        in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        out_data  = res_q;
    end

endmodule

// File: tb/tb_sub_byter_seq.sv
module tb_sub_byter_seq;

    localparam int NI = 6;
    localparam logic [127:0] V0 = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] V1 = 128'h63cab7040953d051cd60e0e7ba70e18c;
    localparam logic [127:0] V2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V2S = 128'h637c777bf26b6fc53001672bfed7ab76;
    localparam logic [127:0] ALL63 = {16{8'h63}};
    localparam logic [127:0] ALL52 = {16{8'h52}};
    localparam logic [127:0] IN53 = 128'h00000000000000000000000000000053;
    localparam logic [127:0] OUT53 = 128'h636363636363636363636363636363ed;

    // Instance 0 is the main LANES=4 engine; 1..4 sweep lanes; 5 is forward-only.
    function automatic int lanes_of(input int i);
        case (i)
            1: return 1;
            2: return 2;
            3: return 8;
            4: return 16;
            default: return 4;
        endcase
    endfunction

    function automatic bit inven_of(input int i);
        return (i != 5);
    endfunction

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [0:127] in_data;
    logic         in_inv;
    logic         out_ready;
    logic         ir [NI];
    logic         ov [NI];
    logic         bz [NI];
    logic [0:127] od [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        sub_byter_seq #(
            .LANES (lanes_of(g)),
            .INV_EN(inven_of(g))
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (ir[g]),
            .in_data  (in_data),
            .in_inv   (in_inv),
            .out_valid(ov[g]),
            .out_ready(out_ready),
            .out_data (od[g]),
            .busy     (bz[g])
        );
    end

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int idx, input logic [127:0] got,
                         input logic [127:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s[%0d] at %0t: got %h, want %h", name, idx, $time, got, want);
        end
    endtask

    // Reference S-box tables built from the field definition by brute-force inversion.
    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [7:0] r;
        r = (x << n) | (x >> (8 - n));
        return r;
    endfunction

    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            logic [7:0] s;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sb[x]  = s;
            isb[s] = 8'(x);
        end
    endtask

    function automatic logic [0:127] m_sub(input logic [0:127] d, input bit inv);
        logic [0:127] r;
        for (int k = 0; k < 16; k++) begin
            r[8 * k +: 8] = inv ? isb[d[8 * k +: 8]] : sb[d[8 * k +: 8]];
        end
        return r;
    endfunction

    // Transaction-level model: a block finishes BEATS edges after acceptance and is held
    // until taken. out_data is only predicted when no block is mid-substitution.
    int           m_cnt   [NI];
    bit           m_run   [NI];
    bit           m_done  [NI];
    bit           m_known [NI];
    logic [0:127] m_out   [NI];
    logic [0:127] m_pend  [NI];

    initial begin
        for (int i = 0; i < NI; i++) begin
            m_cnt[i] = 0; m_run[i] = 0; m_done[i] = 0; m_known[i] = 0;
            m_out[i] = '0; m_pend[i] = '0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            bit take;
            take = 1'b0;
            if (!rst_n) begin
                m_run[i] = 0; m_done[i] = 0; m_known[i] = 1; m_out[i] = '0;
            end else if (m_done[i]) begin
                if (out_ready) begin
                    m_done[i] = 0;
                    take = in_valid;
                end
            end else if (!m_run[i]) begin
                take = in_valid;
            end else begin
                m_cnt[i]--;
                if (m_cnt[i] == 0) begin
                    m_run[i] = 0; m_done[i] = 1; m_out[i] = m_pend[i]; m_known[i] = 1;
                end
            end
            if (take) begin
                m_run[i]   = 1;
                m_cnt[i]   = 16 / lanes_of(i);
                m_pend[i]  = m_sub(in_data, in_inv && inven_of(i));
                m_known[i] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                bit idle;
                idle = !m_run[i] && !m_done[i];
                check("in_ready", i, 128'(ir[i]), 128'(idle || (m_done[i] && out_ready)));
                check("out_valid", i, 128'(ov[i]), 128'(m_done[i]));
                check("busy", i, 128'(bz[i]), 128'(!idle));
                if (m_known[i]) check("out_data", i, od[i], m_out[i]);
            end
        end
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer a block for exactly one cycle; returns just after the accept edge.
    task automatic send(input logic [127:0] d, input logic inv);
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = inv;
        tick(1);
        in_valid = 1'b0;
        in_data  = ~d;
        in_inv   = ~inv;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b1;
        build_tables();
        check("model_fwd", 0, m_sub(V0, 1'b0), V1);
        check("model_inv", 0, m_sub(V1, 1'b1), V0);
        check("model_53", 0, m_sub(IN53, 1'b0), OUT53);
        tick(2);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        check("rst_in_ready", 0, 128'(ir[0]), 128'(1));
        check("rst_out_valid", 0, 128'(ov[0]), 128'(0));
        check("rst_out_data", 0, od[0], '0);
        tick(2);

        // Basic forward with exact latency.
        send(V0, 1'b0);
        tick(3);
        check("lat4_early", 0, 128'(ov[0]), 128'(0));
        tick(1);
        check("lat4_valid", 0, 128'(ov[0]), 128'(1));
        check("fwd_data", 0, od[0], V1);
        tick(20);

        // Inverse; the forward-only instance must still apply the forward table.
        send(V1, 1'b1);
        tick(20);
        check("inv_data", 0, od[0], V0);
        check("inv_ignored", 5, od[5], m_sub(V1, 1'b0));

        // Lane sweep on all-zero input with per-instance latency.
        send('0, 1'b0);
        for (int c = 1; c <= 16; c++) begin
            tick(1);
            for (int i = 1; i <= 4; i++) begin
                if (c == 16 / lanes_of(i) - 1) check("sweep_early", i, 128'(ov[i]), 128'(0));
                if (c == 16 / lanes_of(i)) begin
                    check("sweep_valid", i, 128'(ov[i]), 128'(1));
                    check("sweep_data", i, od[i], ALL63);
                end
            end
        end
        tick(4);
        send(IN53, 1'b0);
        tick(20);
        for (int i = 0; i < NI; i++) check("byte15", i, od[i], OUT53);

        // Backpressure, then retire and accept on the same edge.
        out_ready = 1'b0;
        send(V0, 1'b0);
        tick(16);
        for (int c = 0; c < 5; c++) begin
            tick(1);
            check("bp_valid", 0, 128'(ov[0]), 128'(1));
            check("bp_data", 0, od[0], V1);
            check("bp_in_ready", 0, 128'(ir[0]), 128'(0));
        end
        out_ready = 1'b1;
        send(V2, 1'b0);
        check("b2b_run", 0, 128'(bz[0]), 128'(1));
        check("b2b_retired", 0, 128'(ov[0]), 128'(0));
        tick(4);
        check("b2b_valid", 0, 128'(ov[0]), 128'(1));
        check("b2b_data", 0, od[0], V2S);
        tick(20);

        // Reset during beat 2.
        send(V0, 1'b0);
        tick(2);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("abort_valid", 0, 128'(ov[0]), 128'(0));
        check("abort_data", 0, od[0], '0);
        check("abort_busy", 0, 128'(bz[0]), 128'(0));
        check("abort_ready", 0, 128'(ir[0]), 128'(1));
        tick(20);
        check("abort_quiet", 0, 128'(ov[0]), 128'(0));
        send(V2, 1'b0);
        tick(20);
        check("after_abort", 0, od[0], V2S);

        // Forward-only instance ignores in_inv.
        send('0, 1'b1);
        tick(20);
        check("inven0_fwd", 5, od[5], ALL63);
        check("inven1_inv", 0, od[0], ALL52);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
